// File: rtl/bch63_56_serial_encoder.sv
// Systematic serial BCH(63,56) encoder: passes 56 message bits through, then
// shifts out the 7 parity bits of the division by g(x) = x^7 + x^6 + x^2 + 1.
module bch63_56_serial_encoder #(
  parameter int         N     = 63,
  parameter int         K     = 56,
  parameter logic [6:0] GMASK = 7'b1000101
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_bit,
  output logic in_ready,
  output logic out_valid,
  output logic out_bit,
  output logic out_sop,
  output logic out_eop,
  input  logic out_ready
);

  typedef enum logic {
    MSG,
    PAR
  } state_e;

  state_e     state_q, state_d;
  logic [6:0] r_q, r_d;
  logic [5:0] cnt_q, cnt_d;
  logic       out_valid_q, out_valid_d;
  logic       out_bit_q, out_bit_d;
  logic       out_sop_q, out_sop_d;
  logic       out_eop_q, out_eop_d;

  logic slot_free;
  logic accept;
  logic fb;

  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (state_q == MSG) && slot_free && !rst;
  assign accept    = in_valid && in_ready;
  // Feedback of the remainder LFSR: incoming coefficient plus the x^6 term shifted out.
  assign fb        = in_bit ^ r_q[6];

  always_comb begin
    // NOTE: every _d defaults to its _q first so no path leaves a signal unassigned (no latch).
    state_d     = state_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_bit_d   = out_bit_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;

    if (slot_free) begin
      unique case (state_q)
        MSG: begin
          if (accept) begin
            out_bit_d   = in_bit;
            out_valid_d = 1'b1;
            out_sop_d   = (cnt_q == 6'd0);
            out_eop_d   = 1'b0;
            r_d         = {r_q[5:0], 1'b0} ^ (fb ? GMASK : 7'd0);
            cnt_d       = cnt_q + 6'd1;
            if (cnt_q == 6'(K - 1)) state_d = PAR;
          end else begin
            out_valid_d = 1'b0;
          end
        end
        PAR: begin
          out_bit_d   = r_q[6];
          out_valid_d = 1'b1;
          out_sop_d   = 1'b0;
          out_eop_d   = (cnt_q == 6'(N - 1));
          r_d         = {r_q[5:0], 1'b0};
          cnt_d       = cnt_q + 6'd1;
          if (cnt_q == 6'(N - 1)) begin
            cnt_d   = 6'd0;
            r_d     = 7'd0;
            state_d = MSG;
          end
        end
        default: state_d = MSG;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MSG;
      r_q         <= 7'd0;
      cnt_q       <= 6'd0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;

endmodule

// File: tb/tb_bch63_56_serial_encoder.sv
// Self-checking bench for the serial BCH(63,56) encoder: directed parity vectors,
// reset abort, back-to-back framing and random messages against a long-division model.
module tb_bch63_56_serial_encoder;

  logic clk = 1'b0;
  logic rst, in_valid, in_bit, out_ready;
  logic in_ready, out_valid, out_bit, out_sop, out_eop;

  bch63_56_serial_encoder dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_bit  (out_bit),
    .out_sop  (out_sop),
    .out_eop  (out_eop),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:55] msg;
    logic [0:6]  par;
  } vec_t;

  localparam logic [0:7]  G8        = 8'b11000101;  // g(x) coefficients x^7..x^0
  localparam logic [0:62] SOP_MASK  = {1'b1, 62'd0};
  localparam logic [0:62] EOP_MASK  = {62'd0, 1'b1};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [62:0] act, input logic [62:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Remainder of c(x) mod g(x), index 0 = highest power, by schoolbook long division.
  function automatic logic [0:6] poly_rem(input logic [0:62] cw);
    logic [0:62] c;
    c = cw;
    for (int i = 0; i < 56; i++)
      if (c[i]) c[i +: 8] = c[i +: 8] ^ G8;
    return c[56:62];
  endfunction

  // ---------------- output monitor / scoreboard ----------------
  logic [0:62] exp_q[$];
  logic [0:62] cur_word, cur_sop, cur_eop, last_word;
  int          wcnt = 0, words_done = 0, pushed = 0;
  int          cyc = 0, last_eop_cyc = 0, sop_gap = 0;
  logic        prev_stall = 1'b0;
  logic [3:0]  snap;

  task automatic word_done();
    logic [0:62] e;
    check("word_expected", 63'(exp_q.size() != 0), 63'(1));
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("cw_data", cur_word, e);
    end
    check("cw_sop", cur_sop, SOP_MASK);
    check("cw_eop", cur_eop, EOP_MASK);
    check("cw_even_weight", 63'($countones(cur_word) % 2), 63'(0));
    check("cw_divisible", 63'(poly_rem(cur_word)), 63'(0));
    last_word = cur_word;
    words_done++;
  endtask

  initial begin
    cur_word = '0; cur_sop = '0; cur_eop = '0; last_word = '0; snap = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        wcnt       = 0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          check("stall_hold", 63'({out_valid, out_bit, out_sop, out_eop}), 63'(snap));
        if (out_valid && out_ready) begin
          cur_word[wcnt] = out_bit;
          cur_sop[wcnt]  = out_sop;
          cur_eop[wcnt]  = out_eop;
          if (out_sop) sop_gap = cyc - last_eop_cyc;
          if (out_eop) last_eop_cyc = cyc;
          wcnt++;
          if (wcnt == 63) begin
            word_done();
            wcnt = 0;
          end
        end
        prev_stall = out_valid && !out_ready;
        snap       = {out_valid, out_bit, out_sop, out_eop};
      end
    end
  end

  // ---------------- stimulus helpers (called at posedge + 1) ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_msg(input logic [0:55] m, input bit gaps, input int stop_at);
    int i = 0;
    int budget = 0;
    if (stop_at == 56) begin
      exp_q.push_back({m, poly_rem({m, 7'd0})});
      pushed++;
    end
    while (i < stop_at) begin
      in_valid  = gaps ? ($urandom_range(3) != 0) : 1'b1;
      in_bit    = m[i];
      out_ready = gaps ? ($urandom_range(3) != 0) : 1'b1;
      @(negedge clk);
      if (in_valid && in_ready) i++;
      step();
      budget++;
      if (budget > 5000) begin
        check("send_timeout", 63'(i), 63'(stop_at));
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input bit gaps);
    int b = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && b < 3000) begin
      out_ready = gaps ? ($urandom_range(3) != 0) : 1'b1;
      step();
      b++;
    end
    out_ready = 1'b1;
    repeat (2) step();
    check("drain_done", 63'(exp_q.size()), 63'(0));
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    vec_t        vecs[4];
    logic [0:55] m;
    logic [63:0] rnd;
    int          n, wd;
    bit          seen;

    vecs[0] = '{msg: 56'h0, par: 7'b0000000};
    vecs[1] = '{msg: 56'h1, par: 7'b1000101};  // only index 55 set
    vecs[2] = '{msg: 56'h2, par: 7'b1001111};  // only index 54 set
    vecs[3] = '{msg: 56'h3, par: 7'b0001010};  // 54 and 55: sum of the two above

    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b1;
    step();
    @(negedge clk);
    check("reset_outputs", 63'({out_valid, out_bit, out_sop, out_eop, in_ready}), 63'(0));
    step();
    rst = 1'b0;

    // Directed parity vectors; first one also measures the in_ready parity gap.
    for (int k = 0; k < 4; k++) begin
      wd = words_done;
      send_msg(vecs[k].msg, 1'b0, 56);
      if (k == 0) begin
        n = 0; seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          if (in_ready) seen = 1'b1;
          else if (!seen) n++;
          step();
        end
        check("inready_low_cycles", 63'(n), 63'(7));
      end
      drain(1'b0);
      check("vec_word_count", 63'(words_done - wd), 63'(1));
      check("vec_parity", 63'(last_word[56:62]), 63'(vecs[k].par));
    end

    // Back-to-back codewords: eop of the first then sop of the second on the next cycle.
    rnd = {$urandom(), $urandom()};
    send_msg(rnd[55:0], 1'b0, 56);
    rnd = {$urandom(), $urandom()};
    send_msg(rnd[55:0], 1'b0, 56);
    drain(1'b0);
    check("b2b_sop_after_eop", 63'(sop_gap), 63'(1));

    // Reset while message index 30 is being presented.
    rnd = {$urandom(), $urandom()};
    m   = rnd[55:0];
    send_msg(m, 1'b0, 30);
    rst = 1'b1; in_valid = 1'b1; in_bit = m[30];
    @(negedge clk);
    check("inready_in_reset", 63'(in_ready), 63'(0));
    step();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("post_reset_outputs", 63'({out_valid, out_bit, out_sop, out_eop}), 63'(0));
    step();
    wd = words_done;
    repeat (20) step();
    check("no_partial_parity", 63'({wcnt[15:0], 16'(words_done - wd)}), 63'(0));
    rnd = {$urandom(), $urandom()};
    send_msg(rnd[55:0], 1'b0, 56);
    drain(1'b0);
    check("post_reset_word", 63'(words_done - wd), 63'(1));

    // Random messages with input gaps and output back-pressure.
    for (int k = 0; k < 200; k++) begin
      if (k == 0)      m = '1;
      else if (k == 1) m = {32'hDDDDDDDD, 24'hDDDDDD};
      else begin
        rnd = {$urandom(), $urandom()};
        m   = rnd[55:0];
      end
      send_msg(m, 1'b1, 56);
    end
    drain(1'b1);
    check("word_count", 63'(words_done), 63'(pushed));
    check("no_leftover_bits", 63'(wcnt), 63'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bch63_56_serial_encoder.md
Name: bch63_56_serial_encoder

Overview:
- Systematic serial encoder for the BCH(63,56) code, using generator g(x) = x^7 + x^6 + x^2 + 1 = (x^6 + x + 1)(x + 1).
- Sits directly upstream of the channel/error-injection and decoder stages in the BCH top level.
- Accepts 56 message bits serially and emits the 63-bit codeword serially: the 56 message bits unchanged, then 7 parity bits.
- Codeword bit index 0 is the leftmost (first transmitted) bit and index 62 the rightmost, matching the error-location convention (l1/l2/l3: 0 = left). Index i carries the coefficient of x^(62-i).

Parameters:
- N, 63, codeword length.
- K, 56, message length.
- GMASK, 7'b1000101, low coefficients of g(x) (x^6..x^0), excluding the x^7 term.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  in_bit is valid this cycle.
- in_bit  input  1  message bit, first bit = codeword index 0.
- in_ready  output  1  encoder accepts a message bit this cycle.
- out_valid  output  1  out_bit is valid.
- out_bit  output  1  codeword bit.
- out_sop  output  1  qualifies out_bit as codeword index 0.
- out_eop  output  1  qualifies out_bit as codeword index 62.
- out_ready  input  1  downstream accepts out_bit this cycle.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Outputs: out_valid=0, out_bit=0, out_sop=0, out_eop=0, in_ready=0 in the reset cycle.
  - Internal: state=MSG, parity register r[6:0]=0, bit counter cnt=0.
  - Reset mid-codeword abandons the partial codeword; no parity is emitted for it.
- Slot free: slot_free = !out_valid || out_ready. The output register (out_valid/out_bit/out_sop/out_eop) loads only when slot_free; otherwise it holds all values stable.
- in_ready = (state==MSG) && slot_free && !rst. It is combinational from state, out_valid and out_ready.
- State MSG, accept = in_valid && in_ready:
  - out_bit<=in_bit, out_valid<=1, out_sop<=(cnt==0), out_eop<=0.
  - fb = in_bit ^ r[6]; r <= {r[5:0],1'b0} ^ (fb ? GMASK : 0); cnt<=cnt+1.
  - When accept and cnt==K-1: state<=PAR.
  - If slot_free and no accept, out_valid<=0 (bubble); r and cnt hold.
- State PAR, each cycle with slot_free:
  - out_bit<=r[6], out_valid<=1, out_sop<=0, out_eop<=(cnt==N-1).
  - r<={r[5:0],1'b0}; cnt<=cnt+1.
  - At cnt==N-1: cnt<=0, r<=0, state<=MSG.
- Latency: each accepted message bit appears on out_bit one cycle later.
- Parity emission order: x^6 coefficient first, x^0 last (index 62).
- Throughput: 63 output cycles per 56 input bits. in_ready is low for the 7 parity cycles, so the next codeword's index 0 may be accepted in the cycle after the index-62 bit is loaded.
- Back-pressure: with out_ready=0 and out_valid=1, nothing advances (no accept, r/cnt frozen). No bit is ever dropped or duplicated.
- Simultaneous events: rst has priority over all. in_valid while in PAR is ignored (in_ready=0); the bit must be held upstream.
- Arithmetic: cnt is 6 bits, range 0..62, never wraps past 62. All parity arithmetic is GF(2) XOR.
- Properties every emitted codeword satisfies:
  - Divisible by g(x).
  - Even Hamming weight, since (x+1) divides g.

Test Plan:
- All-zero message, out_ready=1, in_valid continuous -> 63 zero bits, out_sop at index 0, out_eop at index 62, in_ready low for exactly 7 cycles.
- Message with only index 55 = 1 -> parity bits (indices 56..62) = 1,0,0,0,1,0,1. Message with only index 54 = 1 -> parity = 1,0,0,1,1,1,1.
- Indices 54 and 55 both = 1 -> parity = 0,0,0,1,0,1,0 (linearity check).
- 200 random messages (including 56 ones, and message bits taken from the 32-bit pattern 0xDDDDDDDD repeated), with random out_ready/in_valid gaps -> every codeword matches the polynomial reference model, has even weight, and shows no drop/dup; out_* stable while stalled.
- Assert rst=1 at message index 30, then release -> outputs cleared next cycle, no parity emitted for the partial codeword; the next message encodes correctly from index 0.
- Back-to-back codewords with out_ready=1 -> index 62 of codeword n is followed immediately by index 0 of codeword n+1 (out_eop then out_sop on consecutive cycles).
